// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------
// adder_pkg: operation encoding and saturation constants for pipe_adder.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package adder_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;

  localparam int MAX_WIDTH = 64;

  // Clamp value for a width-bit signed result: most negative when neg, else most positive.
  function automatic logic [MAX_WIDTH-1:0] sat_clamp(input logic neg, input int width);
    logic [MAX_WIDTH-1:0] msb_only;
    msb_only = 64'd1 << (width - 1);
    return neg ? msb_only : (msb_only - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_slice.sv
// ---------------------------------------------------------------
// add_slice: W-bit combinational ripple adder with carry in/out.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------
// pipe_adder: STAGES-deep carry-pipelined adder/subtractor, valid/ready.
// Build option PIPE_ADDER_SAT_EN adds signed saturation in the final stage.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_e              op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int W    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % STAGES) != 0 || WIDTH < 4 || WIDTH > 64 || STAGES < 1 || STAGES > 4) begin : g_bad_cfg
    $error("pipe_adder: illegal WIDTH/STAGES combination");
  end

  // Stage registers; a_q/b_q carry the not-yet-added upper slices forward (skew).
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] carry;
  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [WIDTH-1:0]  psum_q [STAGES];
  logic              ovf_q;
  logic              zero_q;

  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] src_cin;
  logic [STAGES-1:0] slc_cout;
  logic [WIDTH-1:0]  src_a    [STAGES];
  logic [WIDTH-1:0]  src_b    [STAGES];
  logic [WIDTH-1:0]  src_psum [STAGES];
  logic [WIDTH-1:0]  nxt_psum [STAGES];
  logic [W-1:0]      slc_sum  [STAGES];

`ifdef PIPE_ADDER_SAT_EN
  logic              sat_q   [STAGES];
  logic              src_sat [STAGES];
`else
  logic              unused_sat;
  assign unused_sat = sat;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src_in
      assign src_vld[k]  = in_valid;
      assign src_a[k]    = a;
      assign src_b[k]    = (op == SUB) ? ~b : b;
      assign src_cin[k]  = (op == SUB) ? 1'b1 : cin;
      assign src_psum[k] = '0;
`ifdef PIPE_ADDER_SAT_EN
      assign src_sat[k]  = sat;
`endif
    end else begin : g_src_prev
      assign src_vld[k]  = vld[k-1];
      assign src_a[k]    = a_q[k-1];
      assign src_b[k]    = b_q[k-1];
      assign src_cin[k]  = carry[k-1];
      assign src_psum[k] = psum_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
      assign src_sat[k]  = sat_q[k-1];
`endif
    end

    add_slice #(.W(W)) u_slice (
      .a    (src_a[k][k*W +: W]),
      .b    (src_b[k][k*W +: W]),
      .cin  (src_cin[k]),
      .sum  (slc_sum[k]),
      .cout (slc_cout[k])
    );

    // Bits at and above slice k are still zero in src_psum, so OR-in is exact.
    assign nxt_psum[k] = src_psum[k] | (WIDTH'(slc_sum[k]) << (k * W));
  end

  // A stage can load if it, or any stage after it, has a hole, or the output retires.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!vld[j]) rdy[k] = 1'b1;
      end
    end
  end

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;

  assign raw_sum = nxt_psum[LAST];
  assign fin_ovf = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                   (raw_sum[WIDTH-1] != src_a[LAST][WIDTH-1]);

`ifdef PIPE_ADDER_SAT_EN
  assign fin_sum = (src_sat[LAST] && fin_ovf) ?
                   WIDTH'(sat_clamp(src_a[LAST][WIDTH-1], WIDTH)) : raw_sum;
`else
  assign fin_sum = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      carry  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        psum_q[k] <= '0;
`ifdef PIPE_ADDER_SAT_EN
        sat_q[k]  <= 1'b0;
`endif
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= src_vld[k];
          if (src_vld[k]) begin
            a_q[k]    <= src_a[k];
            b_q[k]    <= src_b[k];
            carry[k]  <= slc_cout[k];
            psum_q[k] <= (k == LAST) ? fin_sum : nxt_psum[k];
`ifdef PIPE_ADDER_SAT_EN
            sat_q[k]  <= src_sat[k];
`endif
          end
        end
      end
      if (rdy[LAST] && src_vld[LAST]) begin
        ovf_q  <= fin_ovf;
        zero_q <= (fin_sum == '0);
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[LAST];
  assign sum       = psum_q[LAST];
  assign cout      = carry[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// ---------------------------------------------------------------
// tb_pipe_adder: scoreboard bench for pipe_adder at STAGES=2 (main), 1 and 4.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pipe_adder;
  import adder_pkg::*;

`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
    bit          lat_chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        en_other = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  op_e         op = ADD;
  logic        sat = 1'b0;
  logic        out_ready = 1'b1;

  logic        iv_other;
  logic        in_ready [3];
  logic        out_valid [3];
  logic [15:0] sum [3];
  logic        cout [3];
  logic        ovf [3];
  logic        zero [3];

  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc0 = 0;
  bit          lat_mode = 1'b0;
  exp_t        q [3][$];
  bit          hold_v [3];
  logic [18:0] hold_d [3];
  int          lat_of [3] = '{2, 1, 4};

  assign iv_other = in_valid & en_other;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_adder #(.WIDTH(16), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .op(op), .sat(sat),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0])
  );

  pipe_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_other), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .op(op), .sat(sat),
    .out_valid(out_valid[1]), .out_ready(1'b1),
    .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1])
  );

  pipe_adder #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_other), .in_ready(in_ready[2]),
    .a(a), .b(b), .cin(cin), .op(op), .sat(sat),
    .out_valid(out_valid[2]), .out_ready(1'b1),
    .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2])
  );

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi,
                                 input logic ci, input op_e o, input logic si);
    exp_t   e;
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'(ai);
    ub = longint'(bi);
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    if (o == ADD) begin
      ur = ua + ub + longint'(ci);
      sr = sa + sb + longint'(ci);
      e.cout = (ur > 65535);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      e.cout = (ua >= ub);
    end
    e.sum = ur[15:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    if (SAT_EN && si && e.ovf) e.sum = (sr > 0) ? 16'h7FFF : 16'h8000;
    e.zero = (e.sum == 16'h0000);
    e.cyc = cyc;
    e.lat_chk = lat_mode;
    return e;
  endfunction

  task automatic observe(input int id, input logic ov, input logic ordy,
                         input logic [15:0] s, input logic co, input logic of, input logic z);
    exp_t e;
    if (!ov) begin
      hold_v[id] = 1'b0;
      return;
    end
    if (hold_v[id]) begin
      n_vec++;
      if ({s, co, of, z} != hold_d[id]) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %h, want held %h", id, {s, co, of, z}, hold_d[id]);
      end
    end
    if (!ordy) begin
      hold_v[id] = 1'b1;
      hold_d[id] = {s, co, of, z};
      return;
    end
    hold_v[id] = 1'b0;
    n_vec++;
    if (q[id].size() == 0) begin
      n_fail++;
      $display("FAIL spurious[%0d]: got sum=%h with no beat outstanding", id, s);
      return;
    end
    e = q[id].pop_front();
    if ({s, co, of, z} != {e.sum, e.cout, e.ovf, e.zero}) begin
      n_fail++;
      $display("FAIL result[%0d]: got sum=%h cout=%b ovf=%b zero=%b, want sum=%h cout=%b ovf=%b zero=%b",
               id, s, co, of, z, e.sum, e.cout, e.ovf, e.zero);
    end
    if (e.lat_chk) begin
      n_vec++;
      if (cyc - e.cyc != lat_of[id]) begin
        n_fail++;
        $display("FAIL latency[%0d]: got %0d, want %0d", id, cyc - e.cyc, lat_of[id]);
      end
    end
  endtask

  // Monitor and stimulus capture, both sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      observe(0, out_valid[0], out_ready, sum[0], cout[0], ovf[0], zero[0]);
      observe(1, out_valid[1], 1'b1, sum[1], cout[1], ovf[1], zero[1]);
      observe(2, out_valid[2], 1'b1, sum[2], cout[2], ovf[2], zero[2]);
      if (in_valid && in_ready[0]) begin
        q[0].push_back(model(a, b, cin, op, sat));
        acc0++;
      end
      if (iv_other && in_ready[1]) q[1].push_back(model(a, b, cin, op, sat));
      if (iv_other && in_ready[2]) q[2].push_back(model(a, b, cin, op, sat));
    end
  end

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                      input op_e o, input logic si);
    int guard;
    a = ai; b = bi; cin = ci; op = o; sat = si;
    in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready[0] && guard < 50);
    if (!in_ready[0]) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, want 1", in_ready[0]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    n_vec++;
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding, want 0",
               q[0].size() + q[1].size() + q[2].size());
    end
  endtask

  initial begin
    int start;
    int guard;
    for (int i = 0; i < 3; i++) hold_v[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check1("reset_out_valid", 16'(out_valid[i]), 16'h0);
      check1("reset_sum", sum[i], 16'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check1("in_ready_after_reset", 16'(in_ready[0]), 16'h1);

    // Directed vectors on all three depths, latency checked
    out_ready = 1'b1;
    en_other  = 1'b1;
    lat_mode  = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0, ADD, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, SUB, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, SUB, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, SUB, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, ADD, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, ADD, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, ADD, 1'b1);
    drain();
    lat_mode = 1'b0;
    en_other = 1'b0;

    // Random stream with backpressure on the STAGES=2 instance
    start = acc0;
    guard = 0;
    while (acc0 - start < 100 && guard < 3000) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom_range(0, 1));
      op        = op_e'($urandom_range(0, 1));
      sat       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    n_vec++;
    if (acc0 - start < 100) begin
      n_fail++;
      $display("FAIL stream_accept: got %0d beats, want 100", acc0 - start);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with beats in flight
    send(16'h1234, 16'h0001, 1'b0, ADD, 1'b0);
    a = 16'h0101; b = 16'h0202; in_valid = 1'b1;
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check1("rst_flush_out_valid", 16'(out_valid[0]), 16'h0);
    check1("rst_flush_sum", sum[0], 16'h0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      hold_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check1("post_reset_out_valid", 16'(out_valid[0]), 16'h0);
    check1("post_reset_in_ready", 16'(in_ready[0]), 16'h1);
    send(16'h4000, 16'h4000, 1'b0, ADD, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
